// File: rtl/alu_exec_seq.sv
// Registered ALU execute stage: decodes {ALUOp, Funct} and runs single-cycle ops,
// bit-serial shifts and an optional shift-add multiply behind valid/ready handshakes.
module alu_exec_seq #(
    parameter int WIDTH   = 64,
    parameter bit HAS_MUL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALUOp,
    input  logic [3:0]       Funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             taken,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        K_SINGLE = 2'd0,
        K_SHIFT  = 2'd1,
        K_MUL    = 2'd2
    } kind_t;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shop_t;

    state_t           state_r, state_nxt_s;
    kind_t            kind_s;
    shop_t            sh_op_s, sh_op_r;
    logic [WIDTH-1:0] res_s, diff_s, shift_step_s, mul_step_s;
    logic             taken_s, illegal_s, lt_s, ltu_s;
    logic [SHW-1:0]   shamt_s;
    logic [SHW:0]     cnt_r;
    logic [WIDTH-1:0] work_r, mcand_r, plier_r, result_r;
    logic             in_ready_r, out_valid_r, zero_r, taken_r, illegal_r;

    assign diff_s  = a - b;
    assign lt_s    = ($signed(a) < $signed(b));
    assign ltu_s   = (a < b);
    assign shamt_s = b[SHW-1:0];

    // Operation decode and single-cycle result for the operands on the input port
    always_comb begin
        kind_s    = K_SINGLE;
        sh_op_s   = SH_SLL;
        res_s     = '0;
        taken_s   = 1'b0;
        illegal_s = 1'b0;
        case (ALUOp)
            2'b00: res_s = a + b;
            2'b01: begin
                res_s = diff_s;
                case (Funct[2:0])
                    3'b000:  taken_s = (a == b);
                    3'b001:  taken_s = (a != b);
                    3'b100:  taken_s = lt_s;
                    3'b101:  taken_s = ~lt_s;
                    3'b110:  taken_s = ltu_s;
                    3'b111:  taken_s = ~ltu_s;
                    default: begin
                        res_s     = '0;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            2'b10: begin
                case (Funct)
                    4'b0000: res_s = a + b;
                    4'b1000: res_s = diff_s;
                    4'b0001: kind_s = K_SHIFT;
                    4'b0010: res_s = {{(WIDTH-1){1'b0}}, lt_s};
                    4'b0011: res_s = {{(WIDTH-1){1'b0}}, ltu_s};
                    4'b0100: res_s = a ^ b;
                    4'b0101: begin
                        kind_s  = K_SHIFT;
                        sh_op_s = SH_SRL;
                    end
                    4'b1101: begin
                        kind_s  = K_SHIFT;
                        sh_op_s = SH_SRA;
                    end
                    4'b0110: res_s = a | b;
                    4'b0111: res_s = a & b;
                    default: illegal_s = 1'b1;
                endcase
            end
            2'b11: begin
                if ((HAS_MUL == 1'b1) && (Funct[2:0] == 3'b000)) begin
                    kind_s = K_MUL;
                end else begin
                    illegal_s = 1'b1;
                end
            end
            default: illegal_s = 1'b1;
        endcase
    end

    // One-bit shift step and one shift-add multiply step on the working registers
    always_comb begin
        shift_step_s = work_r;
        case (sh_op_r)
            SH_SLL:  shift_step_s = {work_r[WIDTH-2:0], 1'b0};
            SH_SRL:  shift_step_s = {1'b0, work_r[WIDTH-1:1]};
            SH_SRA:  shift_step_s = {work_r[WIDTH-1], work_r[WIDTH-1:1]};
            default: shift_step_s = work_r;
        endcase
        if (plier_r[0]) begin
            mul_step_s = work_r + mcand_r;
        end else begin
            mul_step_s = work_r;
        end
    end

    // FSM next-state selection
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!in_valid) begin
                    state_nxt_s = ST_IDLE;
                end else if ((kind_s == K_SHIFT) && (shamt_s != '0)) begin
                    state_nxt_s = ST_SHIFT;
                end else if (kind_s == K_MUL) begin
                    state_nxt_s = ST_MUL;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_SHIFT, ST_MUL: begin
                if (cnt_r == (SHW+1)'(1)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register, iteration datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= '0;
            zero_r      <= 1'b0;
            taken_r     <= 1'b0;
            illegal_r   <= 1'b0;
            work_r      <= '0;
            mcand_r     <= '0;
            plier_r     <= '0;
            cnt_r       <= '0;
            sh_op_r     <= SH_SLL;
        end else begin
            state_r    <= state_nxt_s;
            in_ready_r <= (state_nxt_s == ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        taken_r   <= 1'b0;
                        illegal_r <= 1'b0;
                        sh_op_r   <= sh_op_s;
                        mcand_r   <= a;
                        plier_r   <= b;
                        if (kind_s == K_SHIFT) begin
                            work_r <= a;
                            cnt_r  <= {1'b0, shamt_s};
                            if (shamt_s == '0) begin
                                result_r    <= a;
                                zero_r      <= (a == '0);
                                out_valid_r <= 1'b1;
                            end
                        end else if (kind_s == K_MUL) begin
                            work_r <= '0;
                            cnt_r  <= (SHW+1)'(WIDTH);
                        end else begin
                            result_r    <= res_s;
                            zero_r      <= (res_s == '0);
                            taken_r     <= taken_s;
                            illegal_r   <= illegal_s;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    work_r <= shift_step_s;
                    cnt_r  <= cnt_r - (SHW+1)'(1);
                    if (cnt_r == (SHW+1)'(1)) begin
                        result_r    <= shift_step_s;
                        zero_r      <= (shift_step_s == '0);
                        out_valid_r <= 1'b1;
                    end
                end
                ST_MUL: begin
                    work_r  <= mul_step_s;
                    mcand_r <= {mcand_r[WIDTH-2:0], 1'b0};
                    plier_r <= {1'b0, plier_r[WIDTH-1:1]};
                    cnt_r   <= cnt_r - (SHW+1)'(1);
                    if (cnt_r == (SHW+1)'(1)) begin
                        result_r    <= mul_step_s;
                        zero_r      <= (mul_step_s == '0);
                        out_valid_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: out_valid_r <= 1'b0;
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = zero_r;
    assign taken     = taken_r;
    assign illegal   = illegal_r;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Bench for alu_exec_seq: directed scenarios plus randomized ops checked against
// an arithmetic reference model, covering latency, handshake hold and reset abort.
module tb_alu_exec_seq;

    localparam int W = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [1:0]    ALUOp = 2'b00;
    logic [3:0]    Funct = 4'b0000;
    logic [W-1:0]  a = '0, b = '0, result;
    logic          zero, taken, illegal;

    logic          nm_in_valid = 1'b0, nm_in_ready, nm_out_valid;
    logic          nm_out_ready = 1'b1;
    logic [W-1:0]  nm_result;
    logic          nm_zero, nm_taken, nm_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_exec_seq #(.WIDTH(W), .HAS_MUL(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .Funct(Funct), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .taken(taken), .illegal(illegal)
    );

    alu_exec_seq #(.WIDTH(W), .HAS_MUL(1'b0)) dut_nomul (
        .clk(clk), .reset(reset), .in_valid(nm_in_valid), .in_ready(nm_in_ready),
        .ALUOp(ALUOp), .Funct(Funct), .a(a), .b(b),
        .out_valid(nm_out_valid), .out_ready(nm_out_ready), .result(nm_result),
        .zero(nm_zero), .taken(nm_taken), .illegal(nm_illegal)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: plain arithmetic on the decoded operation
    function automatic void model(input bit has_mul, input logic [1:0] op, input logic [3:0] fn,
                                  input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic tk, output logic il,
                                  output int lat);
        logic signed [W-1:0] sx, sy;
        int sh;
        sx = x; sy = y; sh = int'(y[5:0]);
        r = '0; tk = 1'b0; il = 1'b0; lat = 1;
        if (op == 2'b00) r = x + y;
        else if (op == 2'b01) begin
            r = x - y;
            case (fn[2:0])
                3'd0: tk = (x == y);
                3'd1: tk = (x != y);
                3'd4: tk = (sx < sy);
                3'd5: tk = (sx >= sy);
                3'd6: tk = (x < y);
                3'd7: tk = (x >= y);
                default: begin r = '0; il = 1'b1; end
            endcase
        end else if (op == 2'b10) begin
            case (fn)
                4'b0000: r = x + y;
                4'b1000: r = x - y;
                4'b0001: begin r = x << sh; lat = 1 + sh; end
                4'b0010: r = (sx < sy) ? 64'd1 : 64'd0;
                4'b0011: r = (x < y) ? 64'd1 : 64'd0;
                4'b0100: r = x ^ y;
                4'b0101: begin r = x >> sh; lat = 1 + sh; end
                4'b1101: begin r = sx >>> sh; lat = 1 + sh; end
                4'b0110: r = x | y;
                4'b0111: r = x & y;
                default: il = 1'b1;
            endcase
        end else begin
            if (has_mul && fn[2:0] == 3'b000) begin r = x * y; lat = 1 + W; end
            else il = 1'b1;
        end
    endfunction

    // Issue one op, measure latency, check outputs, hold under backpressure, then drain
    task automatic run_op(input logic [1:0] op, input logic [3:0] fn,
                          input logic [W-1:0] x, input logic [W-1:0] y, input int hold);
        logic [W-1:0] er;
        logic et, ei, seen, stable;
        int el, k;
        model(1'b1, op, fn, x, y, er, et, ei, el);
        @(negedge clk);
        check("in_ready_before", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1; ALUOp = op; Funct = fn; a = x; b = y; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        k = 0; seen = 1'b0;
        while (!seen && k < W + 10) begin
            @(negedge clk);
            k++;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check($sformatf("latency op=%b fn=%b", op, fn), W'(k), W'(el));
        check("result", result, er);
        check("zero", {63'd0, zero}, {63'd0, (er == '0)});
        check("taken", {63'd0, taken}, {63'd0, et});
        check("illegal", {63'd0, illegal}, {63'd0, ei});
        check("in_ready_busy", {63'd0, in_ready}, 64'd0);
        if (hold > 0) begin
            stable = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (result !== er || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
            end
            check("hold_stable", {63'd0, stable}, 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("out_valid_drop", {63'd0, out_valid}, 64'd0);
        check("in_ready_after", {63'd0, in_ready}, 64'd1);
        check("result_kept", result, er);
    endtask

    initial begin
        logic [1:0] op;
        logic [3:0] fn;
        logic [W-1:0] x, y;
        logic seen;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_flags", {61'd0, zero, taken, illegal}, 64'd0);

        // sub to zero, signed and unsigned less-than branches
        run_op(2'b10, 4'b1000, 64'd5, 64'd5, 0);
        check("sub_zero", {63'd0, zero}, 64'd1);
        run_op(2'b01, 4'b0100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
        check("blt_taken", {63'd0, taken}, 64'd1);
        run_op(2'b01, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
        check("bltu_taken", {63'd0, taken}, 64'd0);

        // shifts, multiply, shamt zero
        run_op(2'b10, 4'b0001, 64'd1, 64'd5, 0);
        check("sll_const", result, 64'd32);
        run_op(2'b10, 4'b1101, 64'h8000_0000_0000_0000, 64'd4, 0);
        check("sra_const", result, 64'hF800_0000_0000_0000);
        run_op(2'b10, 4'b0101, 64'h8000_0000_0000_0000, 64'd4, 0);
        run_op(2'b10, 4'b0001, 64'h1234, 64'd64, 0);
        run_op(2'b11, 4'b0000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        check("mul_const", result, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(2'b01, 4'b1010, 64'd3, 64'd4, 0);

        // multiply decodes as illegal without the multiplier
        @(negedge clk);
        nm_in_valid = 1'b1; ALUOp = 2'b11; Funct = 4'b0000; a = 64'd7; b = 64'd9;
        @(posedge clk);
        #1 nm_in_valid = 1'b0;
        @(negedge clk);
        check("nomul_valid", {63'd0, nm_out_valid}, 64'd1);
        check("nomul_illegal", {63'd0, nm_illegal}, 64'd1);
        check("nomul_result", nm_result, 64'd0);

        // backpressure
        run_op(2'b10, 4'b0100, 64'hDEAD_BEEF_0000_1111, 64'h0F0F_0F0F_0F0F_0F0F, 10);

        // randomized ops
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            fn = 4'($urandom_range(0, 15));
            if (op == 2'b11 && $urandom_range(0, 1) == 1) fn[2:0] = 3'b000;
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) y = x;
            run_op(op, fn, x, y, int'($urandom_range(0, 3)));
        end

        // reset in the middle of a 20-bit shift
        @(negedge clk);
        in_valid = 1'b1; ALUOp = 2'b10; Funct = 4'b0001; a = 64'd1; b = 64'd20;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_in_ready", {63'd0, in_ready}, 64'd1);
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        check("abort_result", result, 64'd0);
        check("abort_flags", {61'd0, zero, taken, illegal}, 64'd0);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        check("abort_no_valid", {63'd0, seen}, 64'd0);
        run_op(2'b00, 4'b0000, 64'd2, 64'd3, 0);
        check("add_after_abort", result, 64'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
